// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers.
// Mode 0: one-shot with a held interrupt. Mode 1: auto-reload with a one-cycle pulse.
module timer_counter #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [3:0]         ctrl, ctrl_next;
    logic [CNT_W-1:0]   preset, preset_next;
    logic [CNT_W-1:0]   count, count_next;
    logic               irq_flag, irq_flag_next;

    logic               wr_ctrl;
    logic               wr_preset;
    logic               en_eff;

    assign wr_ctrl   = we && (addr == 2'd0);
    assign wr_preset = we && (addr == 2'd1);
    // A CTRL write in the same cycle takes effect immediately while counting,
    // so clearing EN on the final count edge suppresses the interrupt.
    assign en_eff    = wr_ctrl ? din[0] : ctrl[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ctrl     <= 4'd0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_next;
            ctrl     <= ctrl_next;
            preset   <= preset_next;
            count    <= count_next;
            irq_flag <= irq_flag_next;
        end
    end

    always_comb begin
        state_next    = state;
        ctrl_next     = wr_ctrl ? din[3:0] : ctrl;
        preset_next   = wr_preset ? din[CNT_W-1:0] : preset;
        count_next    = count;
        irq_flag_next = (wr_ctrl || wr_preset) ? 1'b0 : irq_flag;

        case (state)
            IDLE: begin
                if (ctrl[0]) state_next = LOAD;
            end
            LOAD: begin
                count_next = preset;
                state_next = CNT;
            end
            CNT: begin
                if (!en_eff) begin
                    state_next = IDLE;
                end else if (count > CNT_W'(1)) begin
                    count_next = count - CNT_W'(1);
                end else begin
                    count_next    = '0;
                    irq_flag_next = 1'b1;
                    state_next    = INT;
                end
            end
            INT: begin
                if (ctrl[2:1] == 2'd1) begin
                    irq_flag_next = 1'b0;
                    state_next    = LOAD;
                end else begin
                    // A simultaneous CPU write to CTRL keeps its own EN value.
                    if (!wr_ctrl) ctrl_next[0] = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            2'd0:    dout = {28'd0, ctrl};
            2'd1:    dout = 32'(preset);
            2'd2:    dout = 32'(count);
            default: dout = 32'd0;
        endcase
    end

    assign irq = ctrl[3] & irq_flag;

endmodule
